// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit byte queue.
package uart_pkg;

    localparam int unsigned UART_TXQ_DEPTH_LOG2 = 4;
    localparam int unsigned UART_BYTE_W         = 8;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_ISSUED,
        DRAIN_SENDING
    } drain_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Byte push port from the core plus the data/ok/busy handshake to the UART transmitter.
interface uart_tx_queue_if;
    import uart_pkg::*;

    uart_byte_t in_data;
    logic       in_valid;
    logic       in_ready;
    uart_byte_t tx_data;
    logic       tx_ok;
    logic       tx_busy;

    // master: core and transmitter side; slave: the queue itself
    modport master (
        output in_data, in_valid, tx_busy,
        input  in_ready, tx_data, tx_ok
    );

    modport slave (
        input  in_data, in_valid, tx_busy,
        output in_ready, tx_data, tx_ok
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with explicit occupancy count and a sticky flag for dropped writes.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = UART_TXQ_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                reset,
    input  uart_byte_t          push_data,
    input  logic                push_valid,
    output logic                push_ready_c,
    input  logic                pop,
    output uart_byte_t          head_data_c,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  overflow_q, overflow_d;
    uart_byte_t            mem_q [DEPTH];
    uart_byte_t            mem_d [DEPTH];

    logic do_push;
    logic do_pop;
    logic do_drop;

    // Full and empty come from the count alone; the pointers only address storage.
    assign push_ready_c = (count_q < CW'(DEPTH));
    assign do_push      = push_valid &  push_ready_c;
    assign do_drop      = push_valid & ~push_ready_c;
    assign do_pop       = pop & (count_q != '0);
    assign head_data_c  = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign overflow     = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (do_drop) begin
            overflow_d = 1'b1;
        end

        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the count marks which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue ahead of the UART transmitter: buffers core writes and issues one byte per ok/busy cycle.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = UART_TXQ_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_queue_if.slave      bus,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    output logic                all_sent
);

    drain_state_t state_q, state_d;
    uart_byte_t   tx_data_q, tx_data_d;
    logic         tx_ok_q, tx_ok_d;

    uart_byte_t          head_data_c;
    logic                in_ready_c;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                pop_c;
    logic                issue_c;

    uart_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_data    (bus.in_data),
        .push_valid   (bus.in_valid),
        .push_ready_c (in_ready_c),
        .pop          (pop_c),
        .head_data_c  (head_data_c),
        .count        (fifo_count),
        .overflow     (overflow)
    );

    // Issue uses the registered count, so a byte pushed this cycle waits one cycle.
    assign issue_c = (state_q == DRAIN_IDLE) && (fifo_count != '0) && !bus.tx_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DRAIN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DRAIN_IDLE:    if (issue_c)       state_d = DRAIN_ISSUED;
            DRAIN_ISSUED:  if (bus.tx_busy)   state_d = DRAIN_SENDING;
            DRAIN_SENDING: if (!bus.tx_busy)  state_d = DRAIN_IDLE;
            default:                          state_d = DRAIN_IDLE;
        endcase
    end

    always_comb begin
        pop_c     = 1'b0;
        tx_ok_d   = 1'b0;
        tx_data_d = tx_data_q;
        if (issue_c) begin
            pop_c     = 1'b1;
            tx_ok_d   = 1'b1;
            tx_data_d = head_data_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ok_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_ok_q   <= tx_ok_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.tx_ok    = tx_ok_q;
    assign bus.tx_data  = tx_data_q;
    assign count        = fifo_count;
    assign all_sent     = (fifo_count == '0) && (state_q == DRAIN_IDLE) && !bus.tx_busy;

endmodule
